// File: rtl/requant_pipeline_mc.sv
// Multi-lane requantizer: per-lane ReLU, Q(FRAC) inverse scale, round-half-up, zero point, saturate to OUT_W.
// Three-stage pipeline with one global advance enable, valid/ready handshake and saturation telemetry.
module requant_pipeline_mc #(
  parameter int LANES   = 4,
  parameter int IN_W    = 32,
  parameter int SCALE_W = 16,
  parameter int FRAC    = 8,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*IN_W-1:0]      in_data,
  input  logic                       in_last,
  input  logic                       cfg_relu,
  input  logic [LANES*SCALE_W-1:0]   cfg_inv_scale,
  input  logic [LANES*OUT_W-1:0]     cfg_zero_point,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_W-1:0]     out_data,
  output logic                       out_last,
  output logic [LANES-1:0]           out_sat_mask,
  input  logic                       sat_clear,
  output logic [CNT_W-1:0]           sat_count
);

  localparam int P_W = IN_W + SCALE_W;
  localparam logic signed [P_W-1:0] HALF    = {{(P_W-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [P_W-1:0] OUT_MAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [OUT_W-1:0]      Q_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  logic adv;

  logic signed [IN_W-1:0]  x_relu [LANES];
  logic signed [P_W-1:0]   prod_d [LANES];
  logic                    v1, last1;
  logic signed [P_W-1:0]   prod1  [LANES];
  logic signed [OUT_W-1:0] zp1    [LANES];

  logic signed [P_W-1:0]   biased_d [LANES];
  logic                    v2, last2;
  logic signed [P_W-1:0]   biased2  [LANES];

  logic [LANES*OUT_W-1:0]  q_d;
  logic [LANES-1:0]        mask_d;

  // Whole pipe moves as one; bubbles shift along with valid beats.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x_relu[i] = $signed(in_data[i*IN_W +: IN_W]);
      if (cfg_relu && x_relu[i][IN_W-1]) x_relu[i] = '0;
      prod_d[i] = P_W'(x_relu[i]) * P_W'($signed(cfg_inv_scale[i*SCALE_W +: SCALE_W]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod1[i] <= '0;
        zp1[i]   <= '0;
      end
    end else if (adv) begin
      v1    <= in_valid;
      last1 <= in_last;
      for (int i = 0; i < LANES; i++) begin
        prod1[i] <= prod_d[i];
        zp1[i]   <= $signed(cfg_zero_point[i*OUT_W +: OUT_W]);
      end
    end
  end

  // Adding half an LSB then flooring gives round-half-toward-+inf.
  always_comb begin
    for (int i = 0; i < LANES; i++)
      biased_d[i] = ((prod1[i] + HALF) >>> FRAC) + P_W'(zp1[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      for (int i = 0; i < LANES; i++) biased2[i] <= '0;
    end else if (adv) begin
      v2    <= v1;
      last2 <= last1;
      for (int i = 0; i < LANES; i++) biased2[i] <= biased_d[i];
    end
  end

  always_comb begin
    q_d    = '0;
    mask_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (biased2[i] > OUT_MAX) begin
        q_d[i*OUT_W +: OUT_W] = Q_MAX;
        mask_d[i]             = 1'b1;
      end else if (biased2[i] < OUT_MIN) begin
        q_d[i*OUT_W +: OUT_W] = Q_MIN;
        mask_d[i]             = 1'b1;
      end else begin
        q_d[i*OUT_W +: OUT_W] = biased2[i][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      out_sat_mask <= '0;
    end else if (adv) begin
      out_valid    <= v2;
      out_last     <= last2;
      out_data     <= q_d;
      out_sat_mask <= mask_d;
    end
  end

  // Clear takes priority over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|out_sat_mask) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_requant_pipeline_mc.sv
// Scoreboard bench for requant_pipeline_mc: driver pushes model results, a negedge monitor pops and compares.
module tb_requant_pipeline_mc;
  localparam int LANES = 4, IN_W = 32, SCALE_W = 16, FRAC = 8, OUT_W = 8, CNT_W = 16;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     in_valid, in_ready, in_last, cfg_relu;
  logic [LANES*IN_W-1:0]    in_data;
  logic [LANES*SCALE_W-1:0] cfg_inv_scale;
  logic [LANES*OUT_W-1:0]   cfg_zero_point;
  logic                     out_valid, out_ready, out_last, sat_clear;
  logic [LANES*OUT_W-1:0]   out_data;
  logic [LANES-1:0]         out_sat_mask;
  logic [CNT_W-1:0]         sat_count;

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    logic                   last;
    logic [LANES-1:0]       mask;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, stall_lo = -1, stall_hi = -1, stall_seen = 0;
  int   model_cnt = 0;
  bit   rand_bp = 0, churn = 0;

  always #5 clk = ~clk;

  requant_pipeline_mc #(.LANES(LANES), .IN_W(IN_W), .SCALE_W(SCALE_W), .FRAC(FRAC),
                        .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cfg_relu(cfg_relu),
    .cfg_inv_scale(cfg_inv_scale), .cfg_zero_point(cfg_zero_point),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat_mask(out_sat_mask),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on each lane.
  function automatic exp_t model(input logic [LANES*IN_W-1:0] d, input logic [LANES*SCALE_W-1:0] s,
                                 input logic [LANES*OUT_W-1:0] z, input logic relu, input logic last);
    exp_t e;
    longint x, sc, zp, p, r, b, hi, lo;
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = -hi - 1;
    e.data = '0;
    e.mask = '0;
    e.last = last;
    for (int i = 0; i < LANES; i++) begin
      x  = longint'($signed(d[i*IN_W +: IN_W]));
      sc = longint'($signed(s[i*SCALE_W +: SCALE_W]));
      zp = longint'($signed(z[i*OUT_W +: OUT_W]));
      if (relu && x < 0) x = 0;
      p = x * sc;
      r = (p + (longint'(1) <<< (FRAC-1))) >>> FRAC;
      b = r + zp;
      if (b > hi) begin b = hi; e.mask[i] = 1'b1; end
      else if (b < lo) begin b = lo; e.mask[i] = 1'b1; end
      e.data[i*OUT_W +: OUT_W] = b[OUT_W-1:0];
    end
    return e;
  endfunction

  function automatic logic [LANES*IN_W-1:0] rand_data();
    logic [LANES*IN_W-1:0] d;
    int v;
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(3) == 0) d[i*IN_W +: IN_W] = IN_W'($urandom());
      else begin
        v = int'($urandom_range(4000)) - 2000;
        d[i*IN_W +: IN_W] = IN_W'(v);
      end
    end
    return d;
  endfunction

  function automatic logic [LANES*SCALE_W-1:0] rand_scale();
    logic [LANES*SCALE_W-1:0] s;
    int v;
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(3) == 0) s[i*SCALE_W +: SCALE_W] = SCALE_W'($urandom());
      else begin
        v = int'($urandom_range(1024)) - 512;
        s[i*SCALE_W +: SCALE_W] = SCALE_W'(v);
      end
    end
    return s;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] rand_zp();
    logic [LANES*OUT_W-1:0] z;
    for (int i = 0; i < LANES; i++) z[i*OUT_W +: OUT_W] = OUT_W'($urandom());
    return z;
  endfunction

  // Holds a beat until accepted; expected result uses the config present at the accepting edge.
  task automatic applyStimulus(input logic [LANES*IN_W-1:0] d, input logic [LANES*SCALE_W-1:0] s,
                               input logic [LANES*OUT_W-1:0] z, input logic relu, input logic last,
                               input bit use_given, input logic [LANES*OUT_W-1:0] g_data,
                               input logic [LANES-1:0] g_mask);
    exp_t e;
    int   waitc = 0;
    bit   done = 0;
    in_data = d; cfg_inv_scale = s; cfg_zero_point = z; cfg_relu = relu; in_last = last;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(in_data, cfg_inv_scale, cfg_zero_point, cfg_relu, in_last);
        if (use_given) begin e.data = g_data; e.mask = g_mask; end
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) begin
        waitc++;
        if (churn) cfg_inv_scale = rand_scale();
        if (waitc > 200) begin
          checks++; errors++;
          $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waitc);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
      else if (rand_bp)                       out_ready = ($urandom_range(3) != 0);
      else                                    out_ready = 1'b1;
    end
  end

  initial begin : monitor
    logic [LANES*OUT_W-1:0] prev_data;
    logic                   prev_last;
    logic [LANES-1:0]       prev_mask;
    logic [LANES-1:0]       emask;
    bit                     prev_stall, delivered;
    exp_t                   e;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        model_cnt  = 0;
        prev_stall = 0;
      end else begin
        checkOutput("sat_count", 64'(sat_count), 64'(model_cnt));
        checkOutput("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (cyc >= stall_lo && cyc <= stall_hi && !in_ready) stall_seen++;
        if (prev_stall) begin
          checkOutput("stall_data", 64'(out_data), 64'(prev_data));
          checkOutput("stall_last", 64'(out_last), 64'(prev_last));
          checkOutput("stall_mask", 64'(out_sat_mask), 64'(prev_mask));
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_mask  = out_sat_mask;
        delivered  = out_valid && out_ready;
        emask      = '0;
        if (delivered) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", 64'(out_data), 64'(e.data));
            checkOutput("out_last", 64'(out_last), 64'(e.last));
            checkOutput("out_sat_mask", 64'(out_sat_mask), 64'(e.mask));
            emask = e.mask;
          end
        end
        if (sat_clear) model_cnt = 0;
        else if (delivered && emask != 0 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; cfg_relu = 1'b0;
    cfg_inv_scale = '0; cfg_zero_point = '0; sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_out_last", 64'(out_last), 64'(0));
    checkOutput("rst_mask", 64'(out_sat_mask), 64'(0));
    checkOutput("rst_sat_count", 64'(sat_count), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

    // Pass-through at unity scale, with latency check.
    applyStimulus({32'd127, 32'd0, -32'sd100, 32'd100}, {4{16'h0100}}, '0, 1'b0, 1'b0,
                  1, 32'h7F009C64, 4'b0000);
    @(posedge clk); #1;
    checkOutput("lat_n2_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    checkOutput("lat_n3_valid", 64'(out_valid), 64'(1));
    drain();
    checkOutput("t1_sat_count", 64'(sat_count), 64'(0));

    // Half scale: rounding both signs, saturation high and low.
    applyStimulus({-32'sd1000, 32'd383, -32'sd101, 32'd101}, {4{16'h0080}}, '0, 1'b0, 1'b0,
                  1, 32'h807FCE33, 4'b1100);
    drain();
    checkOutput("t2_sat_count", 64'(sat_count), 64'(1));

    // ReLU with negative and positive zero points.
    applyStimulus({-32'sd1, 32'd0, 32'd40, -32'sd40}, {4{16'h0100}}, {4{8'hFB}}, 1'b1, 1'b0,
                  1, 32'hFBFB23FB, 4'b0000);
    applyStimulus({32'd0, 32'd0, 32'd0, 32'd50}, {4{16'h0100}}, {4{8'd100}}, 1'b1, 1'b0,
                  1, 32'h6464647F, 4'b0001);
    drain();

    // 20-beat stream with a 5-cycle downstream stall; in_last only on the final beat.
    stall_seen = 0;
    stall_lo = cyc + 5; stall_hi = cyc + 9;
    for (int b = 0; b < 20; b++)
      applyStimulus(rand_data(), rand_scale(), rand_zp(), 1'($urandom_range(1)), b == 19, 0, '0, '0);
    drain();
    checkOutput("stall_in_ready_low_cycles", 64'(stall_seen), 64'(5));
    stall_lo = -1; stall_hi = -1;

    // Scale churns every cycle while beats wait; each result follows its accepted config.
    churn = 1;
    stall_lo = cyc + 3; stall_hi = cyc + 8;
    for (int b = 0; b < 10; b++)
      applyStimulus(rand_data(), rand_scale(), rand_zp(), 1'b0, 1'b0, 0, '0, '0);
    drain();
    churn = 0; stall_lo = -1; stall_hi = -1;

    // Clear concurrent with a saturating delivery.
    applyStimulus({32'd0, 32'd0, 32'd0, 32'd50}, {4{16'h0100}}, {4{8'd100}}, 1'b0, 1'b0, 0, '0, '0);
    drain();
    applyStimulus({32'd0, 32'd0, 32'd0, 32'd50}, {4{16'h0100}}, {4{8'd100}}, 1'b0, 1'b0, 0, '0, '0);
    for (int n = 0; n < 10 && !out_valid; n++) begin @(posedge clk); #1; end
    checkOutput("clr_pre_valid", 64'(out_valid), 64'(1));
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    checkOutput("clr_wins", 64'(sat_count), 64'(0));
    drain();

    // Reset with two beats in flight.
    applyStimulus(rand_data(), rand_scale(), rand_zp(), 1'b0, 1'b0, 0, '0, '0);
    applyStimulus(rand_data(), rand_scale(), rand_zp(), 1'b0, 1'b1, 0, '0, '0);
    @(posedge clk); #1;
    checkOutput("rst_mid_pre_valid", 64'(out_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_mid_data", 64'(out_data), 64'(0));
    checkOutput("rst_mid_count", 64'(sat_count), 64'(0));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rst_mid_post_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_mid_post_ready", 64'(in_ready), 64'(1));

    // Randomized traffic with input gaps and random backpressure.
    rand_bp = 1;
    for (int b = 0; b < 300; b++) begin
      applyStimulus(rand_data(), rand_scale(), rand_zp(), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 0, '0, '0);
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end
    rand_bp = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
